// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings common to the RX and TX halves,
// frame geometry constants and a half-bit-period helper.
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] DATA  = 2'b10;
  localparam logic [1:0] STOP  = 2'b11;

  localparam int DATA_BITS = 8;
  localparam int COUNTER_W = 16;
  localparam int IDX_W     = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_START = START,
    S_DATA  = DATA,
    S_STOP  = STOP
  } rx_state_t;

  // Number of counts from the start-bit edge to the middle of the start bit.
  function automatic logic [COUNTER_W-1:0] half_period(input int clks_per_bit);
    return COUNTER_W'((clks_per_bit - 1) / 2);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, byte/strobe/status out.
// master = the receiver, slave = the pin driver / byte consumer.
interface uart_rx_if;

  logic                          i_rx;
  logic [uart_pkg::DATA_BITS-1:0] o_data_byte;
  logic                          o_data_valid;
  logic                          o_active;
  logic                          o_frame_err;

  modport master (
    input  i_rx,
    output o_data_byte, o_data_valid, o_active, o_frame_err
  );

  modport slave (
    output i_rx,
    input  o_data_byte, o_data_valid, o_active, o_frame_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input; flops reset to 1
// so an idle-high line does not look like an edge when reset releases.
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic [1:0] r_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_async};
    end
  end

  assign o_sync = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling at CLKS_PER_BIT clocks per bit.
// Optional macro UART_RX_FRAME_ERR_EN enables stop-bit checking and break lockout.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2813
) (
  input  logic     clock,
  input  logic     reset,
  uart_rx_if.master bus
);

  localparam logic [COUNTER_W-1:0] HALF = half_period(CLKS_PER_BIT);
  localparam logic [COUNTER_W-1:0] LAST = COUNTER_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]     TOP_BIT = IDX_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  rx_state_t            r_state;
  logic [COUNTER_W-1:0] r_count;
  logic [IDX_W-1:0]     r_bit_index;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_byte;
  logic                 r_data_valid;
  logic                 r_active;
`ifdef UART_RX_FRAME_ERR_EN
  logic                 r_frame_err;
  logic                 r_armed;
`endif

  uart_rx_sync u_sync (
    .clock   (clock),
    .reset   (reset),
    .i_async (bus.i_rx),
    .o_sync  (w_rx_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_bit_index  <= '0;
      r_shift      <= '0;
      r_data_byte  <= '0;
      r_data_valid <= 1'b0;
      r_active     <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      r_frame_err  <= 1'b0;
      r_armed      <= 1'b1;
`endif
    end else begin
      r_data_valid <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      r_frame_err  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_count     <= '0;
          r_bit_index <= '0;
`ifdef UART_RX_FRAME_ERR_EN
          // After a bad stop bit the line must return high before a new start counts.
          if (!r_armed) begin
            if (w_rx_s) r_armed <= 1'b1;
          end else if (!w_rx_s) begin
            r_state  <= S_START;
            r_active <= 1'b1;
          end
`else
          if (!w_rx_s) begin
            r_state  <= S_START;
            r_active <= 1'b1;
          end
`endif
        end

        S_START: begin
          if (r_count == HALF) begin
            r_count <= '0;
            if (!w_rx_s) begin
              r_state <= S_DATA;
            end else begin
              r_state  <= S_IDLE;
              r_active <= 1'b0;
            end
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        S_DATA: begin
          if (r_count == LAST) begin
            r_count              <= '0;
            r_shift[r_bit_index] <= w_rx_s;
            if (r_bit_index == TOP_BIT) begin
              r_bit_index <= '0;
              r_state     <= S_STOP;
            end else begin
              r_bit_index <= r_bit_index + 1'b1;
            end
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        S_STOP: begin
          if (r_count == LAST) begin
            r_count  <= '0;
            r_state  <= S_IDLE;
            r_active <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            if (w_rx_s) begin
              r_data_byte  <= r_shift;
              r_data_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
              r_armed     <= 1'b0;
            end
`else
            r_data_byte  <= r_shift;
            r_data_valid <= 1'b1;
`endif
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_count     <= '0;
          r_bit_index <= '0;
          r_active    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_data_byte  = r_data_byte;
  assign bus.o_data_valid = r_data_valid;
  assign bus.o_active     = r_active;
`ifdef UART_RX_FRAME_ERR_EN
  assign bus.o_frame_err  = r_frame_err;
`else
  assign bus.o_frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16; expectations follow
// UART_RX_FRAME_ERR_EN in the same way as the design.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;
  // Line drop to cycle 0 takes three edges (two sync flops, then IDLE detect).
  localparam int VALID_LAT = 3 + 1 + HALF + 9 * CPB;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    bit         err;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  bit   runCompare = 1'b0;
  logic [7:0] modelByte = 8'h00;
  exp_t expQ[$];
  logic [7:0] seenQ[$];
  int   seenCyc[$];
  int   errCount = 0;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives the first nbits line bits (start, 8 data LSB first, stop) with bit
  // k spanning cycles [k*P/100, (k+1)*P/100), P in hundredths of a cycle.
  // Must be entered just after a rising edge.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input int pX100, input int nbits);
    exp_t e;
    int   cur;
    int   nxt;
    logic b;
    if (nbits == 10) begin
      e.cyc  = cyc + VALID_LAT;
      e.data = data;
`ifdef UART_RX_FRAME_ERR_EN
      e.err  = !stopBit;
`else
      e.err  = 1'b0;
`endif
      expQ.push_back(e);
    end
    cur = 0;
    for (int k = 0; k < nbits; k++) begin
      if (k == 0)      b = 1'b0;
      else if (k == 9) b = stopBit;
      else             b = data[k-1];
      bus.i_rx = b;
      nxt = ((k + 1) * pX100 + 50) / 100;
      repeat (nxt - cur) @(posedge clock);
      #1;
      cur = nxt;
    end
  endtask

  task automatic idleLine(input int n);
    bus.i_rx = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_byte"},  bus.o_data_byte,  8'h00);
    checkOutput({tag, "_valid"}, bus.o_data_valid, 1'b0);
    checkOutput({tag, "_active"}, bus.o_active,    1'b0);
    checkOutput({tag, "_ferr"},  bus.o_frame_err,  1'b0);
  endtask

  // Watches o_active/o_data_valid across one nominal frame started this cycle.
  task automatic watchFrame();
    int lows;
    lows = 0;
    for (int i = 0; i <= VALID_LAT; i++) begin
      @(negedge clock);
      if (i == 2) checkOutput("active_before_frame", bus.o_active, 1'b0);
      if (i >= 3 && i < VALID_LAT && !bus.o_active) lows++;
      if (i == VALID_LAT) begin
        checkOutput("active_at_valid", bus.o_active, 1'b0);
        checkOutput("valid_at_153", bus.o_data_valid, 1'b1);
        checkOutput("byte_A5", bus.o_data_byte, 8'hA5);
      end
    end
    checkOutput("active_low_cycles_in_frame", lows, 0);
  endtask

  // Reference model comparison on every cycle outside reset.
  always @(negedge clock) begin
    logic expV;
    logic expE;
    exp_t e;
    if (!reset && runCompare) begin
      expV = 1'b0;
      expE = 1'b0;
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        e = expQ.pop_front();
        if (e.err) expE = 1'b1;
        else begin
          expV = 1'b1;
          modelByte = e.data;
        end
      end
      checkOutput("model_valid", bus.o_data_valid, expV);
      checkOutput("model_byte", bus.o_data_byte, modelByte);
      checkOutput("model_frame_err", bus.o_frame_err, expE);
    end
  end

  always @(negedge clock) begin
    if (!reset && bus.o_data_valid) begin
      seenQ.push_back(bus.o_data_byte);
      seenCyc.push_back(cyc);
    end
    if (!reset && bus.o_frame_err) errCount++;
  end

  initial begin
    logic sawActive;
    bus.i_rx = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkResetOutputs("reset");
    #2 reset = 1'b0;
    idleLine(5);
    runCompare = 1'b1;

    // Ideal 0xA5 frame
    seenQ.delete();
    fork
      applyStimulus(8'hA5, 1'b1, 1600, 10);
      watchFrame();
    join
    idleLine(10);
    checkOutput("a5_count", seenQ.size(), 1);

    // Back-to-back frames, no idle gap
    seenQ.delete();
    seenCyc.delete();
    applyStimulus(8'h00, 1'b1, 1600, 10);
    applyStimulus(8'hFF, 1'b1, 1600, 10);
    applyStimulus(8'h55, 1'b1, 1600, 10);
    idleLine(20);
    checkOutput("b2b_count", seenQ.size(), 3);
    if (seenQ.size() == 3) begin
      checkOutput("b2b_byte0", seenQ[0], 8'h00);
      checkOutput("b2b_byte1", seenQ[1], 8'hFF);
      checkOutput("b2b_byte2", seenQ[2], 8'h55);
      checkOutput("b2b_gap01", seenCyc[1] - seenCyc[0], 160);
      checkOutput("b2b_gap12", seenCyc[2] - seenCyc[1], 160);
    end

    // Five-cycle glitch, then a real frame
    seenQ.delete();
    bus.i_rx = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    bus.i_rx = 1'b1;
    sawActive = 1'b0;
    repeat (20) begin
      @(negedge clock);
      sawActive |= bus.o_active;
    end
    checkOutput("glitch_active_pulse", sawActive, 1'b1);
    checkOutput("glitch_back_idle", bus.o_active, 1'b0);
    checkOutput("glitch_no_valid", seenQ.size(), 0);
    @(posedge clock);
    #1;
    applyStimulus(8'h3C, 1'b1, 1600, 10);
    idleLine(10);
    checkOutput("after_glitch_count", seenQ.size(), 1);
    if (seenQ.size() == 1) checkOutput("after_glitch_byte", seenQ[0], 8'h3C);

    // Frame with the stop bit held low
    seenQ.delete();
    errCount = 0;
    applyStimulus(8'h81, 1'b0, 1600, 10);
    idleLine(30);
`ifdef UART_RX_FRAME_ERR_EN
    checkOutput("stoplow_err_pulses", errCount, 1);
    checkOutput("stoplow_no_valid", seenQ.size(), 0);
    checkOutput("stoplow_byte_held", bus.o_data_byte, 8'h3C);
`else
    checkOutput("stoplow_err_pulses", errCount, 0);
    checkOutput("stoplow_valid_count", seenQ.size(), 1);
    if (seenQ.size() == 1) checkOutput("stoplow_byte", seenQ[0], 8'h81);
`endif

    // Reset during data bit 4
    seenQ.delete();
    applyStimulus(8'h96, 1'b1, 1600, 5);
    bus.i_rx = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    checkOutput("midframe_active", bus.o_active, 1'b1);
    #2;
    reset = 1'b1;
    expQ.delete();
    modelByte = 8'h00;
    #1;
    checkResetOutputs("midreset");
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    idleLine(5);
    checkOutput("midreset_no_valid", seenQ.size(), 0);
    applyStimulus(8'h7E, 1'b1, 1600, 10);
    idleLine(10);
    checkOutput("after_reset_count", seenQ.size(), 1);
    if (seenQ.size() == 1) checkOutput("after_reset_byte", seenQ[0], 8'h7E);

    // Bit period skewed +4% then -4%
    seenQ.delete();
    applyStimulus(8'hC3, 1'b1, 1664, 10);
    idleLine(10);
    applyStimulus(8'hC3, 1'b1, 1536, 10);
    idleLine(10);
    checkOutput("skew_count", seenQ.size(), 2);
    if (seenQ.size() == 2) begin
      checkOutput("skew_slow_byte", seenQ[0], 8'hC3);
      checkOutput("skew_fast_byte", seenQ[1], 8'hC3);
    end

    runCompare = 1'b0;
    checkOutput("pending_expectations", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the board UART: samples the asynchronous serial line, recovers 8N1 frames (1 start, 8 data LSB first, 1 stop) at a fixed baud set by CLKS_PER_BIT, and presents each received byte with a one-cycle valid strobe. It sits between the RX pin and the byte-consumer logic, and pairs with the existing transmitter at the same CLKS_PER_BIT.

## Interface
- CLKS_PER_BIT, default 2813: clock cycles per bit period. Legal range 4..65535. Must match the transmitter.
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_rx  in  1  serial line, asynchronous to clock; idles high.
- o_data_byte  out  8  last received byte; holds until the next valid byte.
- o_data_valid  out  1  one-cycle pulse; o_data_byte is valid in the same cycle.
- o_active  out  1  high while a frame is being received (START/DATA/STOP states).
- o_frame_err  out  1  one-cycle pulse on a bad stop bit; constant 0 unless UART_RX_FRAME_ERR_EN is defined.

## Operation
- i_rx passes through a 2-flop synchronizer; the synchronizer flops reset to 1. rx_s is the synchronizer output, and all FSM decisions use rx_s.
- HALF = (CLKS_PER_BIT-1)/2, truncating integer division. The bit counter is 16 bits wide and is cleared on every state change.
- FSM states:
  - IDLE: counter=0, bit_index=0. If rx_s==0, go to START.
  - START: count to HALF. At counter==HALF, resample rx_s. If it is 0, go to DATA. If it is 1, this is a false start (glitch): return to IDLE with no strobe.
  - DATA: count to CLKS_PER_BIT-1, then shift rx_s into bit[bit_index] (LSB first). bit_index increments 0..7; after bit 7, go to STOP. bit_index wraps to 0.
  - STOP: count to CLKS_PER_BIT-1, then sample rx_s and go to IDLE. If rx_s==1: load o_data_byte and pulse o_data_valid. If rx_s==0: behaviour depends on configuration (see below).
- Unused state encodings go to IDLE.
- Back-to-back frames: IDLE accepts a new start bit on the first cycle after STOP. No idle gap is required.
- Reset mid-frame: all state is discarded immediately and no strobe is issued. Reception resumes at the next falling edge seen on rx_s.

## Timing
- Reset values:
  - o_data_byte=8'h00, o_data_valid=0, o_active=0, o_frame_err=0.
  - state=IDLE, counter=0, bit_index=0, synchronizer=2'b11.
- Define cycle 0 as the edge at which IDLE sees rx_s==0. rx_s lags i_rx by 2 cycles.
- o_active rises at cycle 1. It falls in the same cycle o_data_valid or o_frame_err is asserted, or after a false start.
- Sample of data bit k occurs at cycle 1+HALF+(k+1)*CLKS_PER_BIT. The stop-bit sample occurs at cycle 1+HALF+9*CLKS_PER_BIT.
- o_data_valid (or o_frame_err) is high for exactly one cycle, at cycle 2+HALF+9*CLKS_PER_BIT.

## Configuration
- UART_RX_FRAME_ERR_EN defined:
  - A stop sample of 0 pulses o_frame_err and does not pulse o_data_valid; o_data_byte is not updated.
  - The FSM then waits in IDLE until rx_s==1 has been observed once before arming start detection. This prevents a break condition (line held low) from being decoded as endless 0x00 frames.
- UART_RX_FRAME_ERR_EN not defined:
  - The stop bit is sampled but ignored. o_data_valid pulses and o_data_byte loads regardless of the stop sample.
  - o_frame_err is tied to 0.

## Structure
- Shared package uart_pkg holds:
  - the 2-bit state localparams IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11 (common with the transmitter);
  - the frame constants DATA_BITS=8 and COUNTER_W=16.
- One sub-module, uart_rx_sync: a 2-flop synchronizer with asynchronous reset to 1. It is reusable for other asynchronous inputs.

## Test plan
All scenarios use CLKS_PER_BIT=16 (HALF=7).
- Reset, then drive an ideal 8N1 frame for 0xA5 -> o_data_valid pulses for 1 cycle exactly 153 cycles after rx_s first reads low; o_data_byte=8'hA5; o_active is high throughout the frame.
- Frames 0x00, 0xFF, 0x55 sent back-to-back with no idle gap -> three valid pulses 160 cycles apart, carrying those bytes in order.
- 5-cycle low glitch on i_rx -> no o_data_valid; o_active pulses briefly; the FSM returns to IDLE; a following 0x3C frame is received correctly.
- Frame 0x81 with the stop bit driven low:
  - macro on -> o_frame_err pulses, no valid strobe, o_data_byte keeps its previous value;
  - macro off -> o_data_valid pulses with o_data_byte=8'h81.
- reset asserted at data bit 4 of a frame -> all outputs return to their reset values asynchronously; no strobe; the next 0x7E frame is received correctly.
- Bit period skewed ±4% on the stimulus side, byte 0xC3 -> received correctly in both directions of skew.
